// File: rtl/pll_supervisor.sv
// pll_supervisor: iCE40 PLL start-up/lock supervisor with timed reset, lock timeout, bounded retries and lock-loss recovery.
//   clk, rst_n        : 12 MHz clock, async active-low reset
//   pll_locked        : raw PLL lock (asynchronous)
//   restart           : single-cycle request to re-sequence from scratch
//   pll_resetb        : PLL RESETB (active-low)
//   sys_rst_n, ready  : downstream reset release / RUN indicator
//   fault             : lock never achieved within the retry budget
//   retry_count       : retries used in the current sequence
//   lock_loss_count   : saturating count of lock losses seen in RUN
module pll_supervisor #(
    parameter int PLL_RST_CYCLES = 12,
    parameter int LOCK_TIMEOUT   = 1200000,
    parameter int LOCK_STABLE    = 12000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count
);
    localparam int TMAX = (LOCK_TIMEOUT > PLL_RST_CYCLES)
                        ? ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE)
                        : ((PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE);
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            sync1_q, lock_s_q;
    logic [1:0]      retry_q, retry_d;
    logic [7:0]      llc_q, llc_d;
    logic            pll_resetb_q, pll_resetb_d;
    logic            sys_rst_n_q, sys_rst_n_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        unique case (state_q)
            RESET_PLL: state_d = (timer_q == TW'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: begin
                if (lock_s_q)
                    state_d = STABLE;
                else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d = (retry_q == 2'(MAX_RETRIES)) ? FAULT : RESET_PLL;
                    retry_d = (retry_q == 2'(MAX_RETRIES)) ? retry_q : retry_q + 2'd1;
                end
            end
            STABLE: state_d = !lock_s_q ? WAIT_LOCK
                            : (timer_q == TW'(LOCK_STABLE - 1)) ? RUN : STABLE;
            RUN: begin
                if (!lock_s_q) begin
                    state_d = RESET_PLL;
                    retry_d = 2'd0;
                    llc_d   = (llc_q == 8'hff) ? llc_q : llc_q + 8'd1;
                end
            end
            default: state_d = FAULT;
        endcase
        // restart overrides the transition but not the lock-loss count
        if (restart) begin
            state_d = RESET_PLL;
            retry_d = 2'd0;
        end
        // timer restarts on every state entry, including a restart into RESET_PLL
        timer_d      = (state_d != state_q || restart) ? '0 : timer_q + 1'b1;
        pll_resetb_d = !(state_d == RESET_PLL || state_d == FAULT);
        sys_rst_n_d  = state_d == RUN;
        ready_d      = state_d == RUN;
        fault_d      = state_d == FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            timer_q      <= '0;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            retry_q      <= 2'd0;
            llc_q        <= 8'd0;
            pll_resetb_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sync1_q      <= pll_locked;
            lock_s_q     <= sync1_q;
            retry_q      <= retry_d;
            llc_q        <= llc_d;
            pll_resetb_q <= pll_resetb_d;
            sys_rst_n_q  <= sys_rst_n_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed + randomized checks of pll_supervisor against a timestamp-based phase model.
module tb_pll_supervisor;
    localparam int PRC = 4, LT = 20, LS = 8, MR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb, sys_rst_n, ready, fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    int vectors = 0;
    int errors  = 0;

    pll_supervisor #(
        .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
        .pll_resetb(pll_resetb), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    typedef enum {PH_RST, PH_WAIT, PH_STAB, PH_RUN, PH_FAULT} phase_t;
    phase_t phase;
    int     cyc, entered, m_retry, m_losses;
    bit     lq[$];

    function automatic logic [13:0] dut_vec();
        return {pll_resetb, sys_rst_n, ready, fault, retry_count, lock_loss_count};
    endfunction

    function automatic logic [13:0] model_vec();
        return {phase != PH_RST && phase != PH_FAULT, phase == PH_RUN, phase == PH_RUN,
                phase == PH_FAULT, 2'(m_retry), 8'(m_losses)};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = PH_RST; cyc = 0; entered = 0; m_retry = 0; m_losses = 0;
        lq = {1'b0, 1'b0};
    endtask

    // One clock edge of the reference: lock is seen two edges late, dwell time is cyc - entered.
    task automatic model_edge();
        bit     ls;
        int     age;
        phase_t nxt;
        ls  = lq.pop_front();
        lq.push_back(pll_locked);
        age = cyc - entered;
        nxt = phase;
        if (phase == PH_RST && age == PRC - 1) nxt = PH_WAIT;
        if (phase == PH_WAIT) begin
            if (ls) nxt = PH_STAB;
            else if (age == LT - 1) begin
                if (m_retry == MR) nxt = PH_FAULT;
                else begin m_retry++; nxt = PH_RST; end
            end
        end
        if (phase == PH_STAB) nxt = !ls ? PH_WAIT : (age == LS - 1) ? PH_RUN : PH_STAB;
        if (phase == PH_RUN && !ls) begin
            m_losses = (m_losses < 255) ? m_losses + 1 : 255;
            m_retry  = 0;
            nxt      = PH_RST;
        end
        if (restart) begin nxt = PH_RST; m_retry = 0; end
        cyc++;
        if (nxt != phase || restart) entered = cyc;
        phase = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset", dut_vec(), model_vec());
        check("reset_const", dut_vec(), 14'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int prev;
        #2;
        // best-case release with lock tied high
        pll_locked = 1'b1;
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            step();
            if (e <= 3) check("resetb_low", 14'(pll_resetb), 14'd0);
            if (e == 4) check("resetb_high", 14'(pll_resetb), 14'd1);
            if (e == 12) check("sysrst_e12", 14'(sys_rst_n), 14'd0);
            if (e == 13) check("release_e13", {12'd0, sys_rst_n, ready}, 14'd3);
        end
        repeat (5) step();
        // lock loss in RUN: sys_rst_n falls on the third edge
        pll_locked = 1'b0;
        step(); check("loss_e1", 14'(sys_rst_n), 14'd1);
        step(); check("loss_e2", 14'(sys_rst_n), 14'd1);
        step(); check("loss_e3", {5'd0, sys_rst_n, lock_loss_count}, 14'd1);
        pll_locked = 1'b1;
        repeat (20) step();
        check("relock_ready", 14'(ready), 14'd1);

        // lock never asserts: fault after three attempts
        pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            step();
            if (e == 71) check("fault_e71", 14'(fault), 14'd0);
            if (e == 72) check("fault_e72", {11'd0, fault, retry_count}, 14'b110);
        end
        repeat (10) step();
        check("fault_hold", {12'd0, pll_resetb, sys_rst_n}, 14'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_fault", {11'd0, fault, retry_count}, 14'd0);
        step();
        check("restart_resetb", 14'(pll_resetb), 14'd0);
        pll_locked = 1'b1;
        repeat (20) step();

        // one-cycle lock glitch while in STABLE
        do_reset();
        for (int e = 1; e <= 19; e++) begin
            if (e == 8) pll_locked = 1'b0;
            if (e == 9) pll_locked = 1'b1;
            step();
            if (e == 13) check("glitch_e13", 14'(ready), 14'd0);
            if (e == 18) check("glitch_e18", 14'(ready), 14'd0);
            if (e == 19) check("glitch_e19", {11'd0, ready, retry_count}, 14'b100);
        end

        // restart coinciding with a RUN lock loss
        repeat (3) step();
        prev = int'(lock_loss_count);
        pll_locked = 1'b0;
        step();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        pll_locked = 1'b1;
        check("restart_loss", 14'(lock_loss_count), 14'(prev + 1));
        repeat (20) step();
        check("restart_loss_once", 14'(lock_loss_count), 14'(prev + 1));

        // randomized lock wander and occasional restarts
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(11) == 0) pll_locked = ~pll_locked;
            restart = ($urandom_range(149) == 0);
            step();
        end
        restart = 1'b0;

        // lock-loss counter saturation
        do_reset();
        for (int k = 0; k < 258; k++) begin
            pll_locked = 1'b1;
            repeat (18) step();
            pll_locked = 1'b0;
            repeat (2) step();
        end
        pll_locked = 1'b1;
        repeat (4) step();
        check("llc_saturate", 14'(lock_loss_count), 14'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Start-up and lock supervisor for the iCE40 PLL. Runs on the external 12 MHz clock and holds the PLL in reset for a fixed time. It then waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing a synchronous reset to the PLL-clocked logic. On lock loss it re-asserts system reset and re-sequences the PLL, and it reports status for the LED and debug pins.

## Interface
Parameters:
- PLL_RST_CYCLES, 12: cycles pll_resetb is held low per attempt (1 µs at 12 MHz); ≥1
- LOCK_TIMEOUT, 1200000: cycles allowed in WAIT_LOCK per attempt (100 ms); ≥2
- LOCK_STABLE, 12000: consecutive synchronized-lock cycles required before release (1 ms); ≥1
- MAX_RETRIES, 3: retries after the first attempt before FAULT; 0..3

Ports:
- clk  in  1  external 12 MHz clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  raw PLL LOCK output (asynchronous to clk)
- restart  in  1  single-cycle request to re-sequence the PLL from scratch
- pll_resetb  out  1  PLL RESETB, active-low
- sys_rst_n  out  1  active-low reset for downstream logic; high only in RUN
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- retry_count  out  2  retries used in the current sequence
- lock_loss_count  out  8  saturating count of lock losses seen in RUN

## Operation
- pll_locked passes through a 2-flop synchronizer, producing lock_s. Both flops reset to 0.
- One timer shared by all states. It clears to 0 on every state entry.
- All outputs are registers, updated on the same edge as the state register, so they reflect the state being entered.
- States and transitions:
  - RESET_PLL: pll_resetb=0, sys_rst_n=0. After timer reaches PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_resetb=1, sys_rst_n=0.
    - lock_s=1: go to STABLE.
    - Else, if timer reaches LOCK_TIMEOUT-1: go to FAULT when retry_count==MAX_RETRIES; otherwise increment retry_count and go to RESET_PLL.
  - STABLE: pll_resetb=1, sys_rst_n=0.
    - lock_s=0: go to WAIT_LOCK with the timer restarted; retry_count unchanged.
    - Timer reaches LOCK_STABLE-1 with lock_s=1: go to RUN.
  - RUN: sys_rst_n=1, ready=1.
    - lock_s=0: increment lock_loss_count (saturating at 255), clear retry_count, go to RESET_PLL.
  - FAULT: pll_resetb=0, sys_rst_n=0, fault=1. Held until restart or rst_n.
- restart=1 in any state, including RESET_PLL and FAULT:
  - Next state is RESET_PLL, retry_count cleared, timer cleared.
  - restart has priority over all other transitions.
  - If it coincides with lock_s=0 in RUN, lock_loss_count still increments.
- lock_loss_count clears only on rst_n.

## Timing
- Reset values (rst_n low, asynchronous):
  - state=RESET_PLL, pll_resetb=0, sys_rst_n=0, ready=0, fault=0
  - retry_count=0, lock_loss_count=0, timer=0, synchronizer=0
- Lock input latency: a pll_locked edge is visible on lock_s 2 clk edges later.
- Lock loss in RUN: sys_rst_n goes low 3 edges after the pll_locked fall (2 synchronizer + 1 state).
- Best-case release, with lock already high: sys_rst_n rises PLL_RST_CYCLES + 1 + LOCK_STABLE edges after the first edge following rst_n deassertion. This is 1 cycle in WAIT_LOCK plus LOCK_STABLE cycles in STABLE.
- Each attempt pulses pll_resetb low for exactly PLL_RST_CYCLES cycles.
- Time to FAULT with lock never asserted: (MAX_RETRIES+1)×(PLL_RST_CYCLES+LOCK_TIMEOUT) cycles.
- restart: takes effect on the next edge; pll_resetb is low the following cycle.

## Test plan
Benches use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
- Lock tied high, release rst_n → pll_resetb low for edges 1–4; sys_rst_n and ready rise at edge 13; fault=0; retry_count=0.
- Lock tied low → three 4-cycle pll_resetb pulses; fault=1 at edge 72 with retry_count=2; pll_resetb and sys_rst_n stay 0 thereafter.
- Lock high, then low for 1 cycle during STABLE cycle 5 → return to WAIT_LOCK then STABLE; ready delayed by the glitch; retry_count stays 0.
- In RUN, drop pll_locked → sys_rst_n low 3 edges later; lock_loss_count=1; 4-cycle pll_resetb pulse; relock gives ready again after 1+8 cycles.
- In FAULT, pulse restart → fault=0 the next edge; retry_count=0; new RESET_PLL pulse. Also pulse restart together with a RUN lock loss → a single RESET_PLL entry and lock_loss_count incremented by exactly 1.
- Force 256 lock losses in RUN → lock_loss_count holds at 255.
